fetch_ctrl: RTL

Instruction-fetch sequencer for the 5-stage pipeline: owns the architectural PC register, issues requests to instruction memory over a valid/ready handshake, and loads the IF/ID pipeline register. It consumes the redirect (Branch/PC_out) and halt decisions produced in ID, and the stall from the hazard unit. It also absorbs multi-cycle memory latency with a one-entry skid buffer and discards responses squashed by a redirect or halt.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/add_16b.sv | 15 +
 rtl/fetch_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch sequencer
package fetch_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  // Distance between consecutive instruction words (byte addressing, 16-bit words)
  localparam logic [PC_W-1:0] PC_STEP = 16'h2;

  typedef enum logic [1:0] {
    ST_FETCH      = 2'd0,
    ST_DISCARD    = 2'd1,
    ST_HALT_DRAIN = 2'd2,
    ST_HALT       = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/add_16b.sv
// rtl/add_16b.sv - 16-bit ripple adder with carry in/out
module add_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  // Full-width add; the carry out is the 17th bit of the result
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC owner, imem request sequencer and IF/ID register loader
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt_dec,
  output logic               if_valid,
  output logic [PC_W-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               halted
);

  fetch_state_t       state;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    tgt;
  logic [PC_W-1:0]    pc_next;
  logic               pc_cout_unused;
  logic               skid_valid;
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic               complete;
  logic               pending;

  // Sequential PC for the next fetch
  add_16b u_pc_add (
    .a    (pc),
    .b    (PC_STEP),
    .cin  (1'b0),
    .sum  (pc_next),
    .cout (pc_cout_unused)
  );

  // Request is driven straight from state so it stays stable while memory waits;
  // a full skid buffer blocks new requests until it drains into IF/ID
  always_comb begin
    imem_req  = ~rst & ~skid_valid &
                ((state == ST_FETCH) | (state == ST_DISCARD) | (state == ST_HALT_DRAIN));
    imem_addr = pc;
    complete  = imem_req & imem_ready;
    pending   = imem_req & ~imem_ready;
  end

  // Fetch FSM with PC, redirect target, skid buffer and IF/ID registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_FETCH;
      pc         <= RESET_PC;
      tgt        <= '0;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= '0;
      if_valid   <= 1'b0;
      if_pc      <= '0;
      if_instr   <= '0;
      halted     <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (halt_dec) begin
            // An outstanding request must still be retired before going idle
            if_valid   <= 1'b0;
            skid_valid <= 1'b0;
            state      <= pending ? ST_HALT_DRAIN : ST_HALT;
            halted     <= ~pending;
          end else if (redirect_valid) begin
            if_valid   <= 1'b0;
            skid_valid <= 1'b0;
            if (pending) begin
              tgt   <= redirect_pc;
              state <= ST_DISCARD;
            end else begin
              pc <= redirect_pc;
            end
          end else if (stall) begin
            // IF/ID is frozen; park a completing response in the skid buffer
            if (complete) begin
              skid_valid <= 1'b1;
              skid_pc    <= pc;
              skid_instr <= imem_data;
              pc         <= pc_next;
            end
          end else if (skid_valid) begin
            if_valid   <= 1'b1;
            if_pc      <= skid_pc;
            if_instr   <= skid_instr;
            skid_valid <= 1'b0;
          end else if (complete) begin
            if_valid <= 1'b1;
            if_pc    <= pc;
            if_instr <= imem_data;
            pc       <= pc_next;
          end else begin
            if_valid <= 1'b0;
          end
        end

        ST_DISCARD: begin
          // Wait out the squashed request; its data never reaches IF/ID
          if_valid <= 1'b0;
          if (halt_dec) begin
            state  <= pending ? ST_HALT_DRAIN : ST_HALT;
            halted <= ~pending;
          end else if (complete) begin
            pc    <= redirect_valid ? redirect_pc : tgt;
            state <= ST_FETCH;
          end else if (redirect_valid) begin
            tgt <= redirect_pc;
          end
        end

        ST_HALT_DRAIN: begin
          if_valid <= 1'b0;
          if (complete) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end
        end

        ST_HALT: begin
          halted <= 1'b1;
        end

        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule
